// File: rtl/room_thermal_model_pkg.sv
// Shared thermal plant definitions: the mode encoding, the default temperature
// width and the clamp helper. The thermostat controller bench uses these too.
package thermal_pkg;

    // The encoding matches {h, c}, so decoding a mode is a plain cast.
    typedef enum logic [1:0] {
        DRIFT = 2'b00,
        COOL  = 2'b01,
        HEAT  = 2'b10,
        FAULT = 2'b11
    } mode_t;

    localparam int THERMAL_WIDTH = 5;

    // Limit a value to the range [min_v, max_v].
    function automatic int clamp_temp(input int value, input int min_v, input int max_v);
        if (value < min_v) begin
            return min_v;
        end
        if (value > max_v) begin
            return max_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/room_thermal_model_step_timer.sv
// Step prescaler: counts enabled cycles and emits a single-cycle tick on the
// cycle in which the count reaches div-1. A restart drops any partial progress.
module step_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       enable,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt_reg;
    logic       at_end;

    assign at_end = (cnt_reg == (div - 8'd1));
    assign tick   = enable && !restart && at_end;

    // Divider count: cleared by reset or restart, wraps to zero on each tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 8'd0;
        end else if (restart) begin
            cnt_reg <= 8'd0;
        end else if (enable) begin
            if (at_end) begin
                cnt_reg <= 8'd0;
            end else begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

endmodule

// File: rtl/room_thermal_model.sv
// Room thermal plant: turns the heat and cool commands into a rate-limited,
// saturating 5-bit room temperature that drifts toward ambient when idle.
module room_thermal_model
    import thermal_pkg::*;
#(
    parameter int WIDTH     = THERMAL_WIDTH,
    parameter int TEMP_INIT = 15,
    parameter int TEMP_MIN  = 0,
    parameter int TEMP_MAX  = 31,
    parameter int AMBIENT   = 18,
    parameter int HEAT_DIV  = 4,
    parameter int COOL_DIV  = 4,
    parameter int DRIFT_DIV = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             h,
    input  logic             c,
    input  logic             load,
    input  logic [WIDTH-1:0] load_temp,
    output logic [WIDTH-1:0] temp,
    output logic             fault
);

    localparam logic [WIDTH:0] MIN_EXT = TEMP_MIN[WIDTH:0];
    localparam logic [WIDTH:0] MAX_EXT = TEMP_MAX[WIDTH:0];
    localparam logic [WIDTH:0] AMB_EXT = AMBIENT[WIDTH:0];
    localparam int             DIVS [3] = '{HEAT_DIV, COOL_DIV, DRIFT_DIV};

    mode_t            mode;
    mode_t            state_reg;
    logic [WIDTH-1:0] temp_reg;
    logic             fault_reg;
    logic             mode_change;
    logic             restart;
    logic             enable;
    logic             tick;
    logic [7:0]       div_sel;
    logic [WIDTH:0]   temp_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH-1:0] load_clamped;

    assign mode        = mode_t'({h, c});
    assign mode_change = (mode != state_reg);
    // FAULT keeps the divider parked at zero so a later release starts clean.
    assign restart     = load || mode_change || (state_reg == FAULT);
    assign enable      = !restart;

    assign temp_ext     = {1'b0, temp_reg};
    assign load_clamped = WIDTH'(clamp_temp(int'(load_temp), TEMP_MIN, TEMP_MAX));

    assign temp  = temp_reg;
    assign fault = fault_reg;

    // Pick the step divisor for the mode currently being held.
    always_comb begin
        div_sel = 8'd1;
        case (state_reg)
            HEAT:    div_sel = 8'(HEAT_DIV);
            COOL:    div_sel = 8'(COOL_DIV);
            DRIFT:   div_sel = 8'(DRIFT_DIV);
            default: div_sel = 8'd1;
        endcase
    end

    // Next temperature if a step fires, computed one bit wider so it cannot wrap.
    always_comb begin
        step_ext = temp_ext;
        case (state_reg)
            HEAT:  step_ext = (temp_ext >= MAX_EXT) ? MAX_EXT : temp_ext + 1'b1;
            COOL:  step_ext = (temp_ext <= MIN_EXT) ? MIN_EXT : temp_ext - 1'b1;
            DRIFT: begin
                if (temp_ext < AMB_EXT) begin
                    step_ext = temp_ext + 1'b1;
                end else if (temp_ext > AMB_EXT) begin
                    step_ext = temp_ext - 1'b1;
                end
            end
            default: step_ext = temp_ext;
        endcase
    end

    step_timer u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .enable  (enable),
        .div     (div_sel),
        .tick    (tick)
    );

    // Mode, fault flag and temperature registers: reset, then load, then step.
    always_ff @(posedge clk) begin
        if (rst) begin
            temp_reg  <= WIDTH'(TEMP_INIT);
            fault_reg <= 1'b0;
            state_reg <= DRIFT;
        end else begin
            state_reg <= mode;
            fault_reg <= (mode == FAULT);
            if (load) begin
                temp_reg <= load_clamped;
            end else if (tick) begin
                temp_reg <= step_ext[WIDTH-1:0];
            end
        end
    end

    // Flag any divisor outside the 8-bit divider's legal range.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_div_check
            always_ff @(posedge clk) begin
                assert (DIVS[gi] >= 1 && DIVS[gi] <= 255);
            end
        end
    endgenerate

endmodule

// File: tb/tb_room_thermal_model.sv
// Bench for room_thermal_model: directed scenarios, randomized mode bursts and a
// simple closed loop, all checked against a run-length based reference model.
module tb_room_thermal_model;
    import thermal_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       h = 1'b0;
    logic       c = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_temp = 5'd0;
    logic [4:0] temp;
    logic       fault;

    int total = 0;
    int bad   = 0;

    // Reference model: temperature, held mode and edges spent in that mode.
    int         m_temp  = 15;
    logic [1:0] m_mode  = 2'b00;
    int         m_run   = 0;
    logic       m_fault = 1'b0;

    room_thermal_model dut (
        .clk       (clk),
        .rst       (rst),
        .h         (h),
        .c         (c),
        .load      (load),
        .load_temp (load_temp),
        .temp      (temp),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int div_for(input logic [1:0] m);
        case (m)
            2'b10:   return 4;
            2'b01:   return 4;
            default: return 16;
        endcase
    endfunction

    // One degree of change for the held mode, saturating at 0 and 31.
    function automatic int stepped(input logic [1:0] m, input int t);
        case (m)
            2'b10:   return (t >= 31) ? 31 : t + 1;
            2'b01:   return (t <= 0) ? 0 : t - 1;
            2'b00:   return (t < 18) ? t + 1 : ((t > 18) ? t - 1 : t);
            default: return t;
        endcase
    endfunction

    // Every D-th consecutive edge spent in a mode (after the entry edge) steps.
    task automatic model_edge(input logic r, input logic ld, input logic [4:0] lt,
                              input logic hh, input logic cc);
        logic [1:0] md;
        md = {hh, cc};
        if (r) begin
            m_temp = 15; m_mode = 2'b00; m_run = 0; m_fault = 1'b0;
        end else if (ld) begin
            m_temp = clamp_temp(int'(lt), 0, 31);
            m_mode = md; m_run = 0; m_fault = (md == 2'b11);
        end else if (md != m_mode) begin
            m_mode = md; m_run = 0; m_fault = (md == 2'b11);
        end else begin
            m_fault = (md == 2'b11);
            if (md != 2'b11) begin
                m_run++;
                if (m_run % div_for(md) == 0) begin
                    m_temp = stepped(md, m_temp);
                end
            end
        end
    endtask

    // Drive one edge's inputs, advance the model, then check both outputs.
    task automatic cycle(input logic r, input logic ld, input logic [4:0] lt,
                         input logic hh, input logic cc, input string tag);
        rst = r; load = ld; load_temp = lt; h = hh; c = cc;
        @(posedge clk);
        model_edge(r, ld, lt, hh, cc);
        #1;
        check_val({tag, "_temp"}, 32'(temp), 32'(m_temp));
        check_val({tag, "_fault"}, 32'(fault), 32'(m_fault));
    endtask

    initial begin
        int len;
        int pick;
        logic hh;
        logic cc;

        // Reset state
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, "reset");
        check_val("reset_temp_const", 32'(temp), 32'd15);
        check_val("reset_fault_const", 32'(fault), 32'd0);
        $display("scenario reset: temp=%0d fault=%0d", temp, fault);

        // Heating from reset: entry edge plus four held edges per step
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "heat");
        check_val("heat_two_steps", 32'(temp), 32'd17);
        $display("scenario heat: temp=%0d", temp);

        // Load 30 then heat: saturates at 31 without wrapping
        cycle(1'b0, 1'b1, 5'd30, 1'b1, 1'b0, "load30");
        check_val("load30_value", 32'(temp), 32'd30);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "heat_sat");
        check_val("heat_reach_max", 32'(temp), 32'd31);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "heat_sat");
        check_val("heat_hold_max", 32'(temp), 32'd31);
        $display("scenario heat_saturate: temp=%0d", temp);

        // Load 2 then cool: 1, 0, then stays at 0
        cycle(1'b0, 1'b1, 5'd2, 1'b0, 1'b1, "load2");
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "cool_sat");
        check_val("cool_hold_min", 32'(temp), 32'd0);
        $display("scenario cool_saturate: temp=%0d", temp);

        // Drift from reset: 16, 17, 18 at edges 16, 32, 48, then constant
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, "rst2");
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "drift_up");
        check_val("drift_edge16", 32'(temp), 32'd16);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "drift_up");
        check_val("drift_ambient", 32'(temp), 32'd18);
        cycle(1'b0, 1'b1, 5'd21, 1'b0, 1'b0, "load21");
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "drift_down");
        check_val("drift_down16", 32'(temp), 32'd20);
        $display("scenario drift: temp=%0d", temp);

        // Fault mid-heat: temperature frozen, flag set, then heat restarts
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "pre_fault");
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, "fault");
        check_val("fault_set", 32'(fault), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, "fault");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, "post_fault");
        check_val("fault_clear", 32'(fault), 32'd0);
        $display("scenario fault: temp=%0d fault=%0d", temp, fault);

        // Randomized bursts of held modes, with occasional load and reset
        for (int s = 0; s < 60; s++) begin
            pick = int'($urandom_range(0, 9));
            hh = (pick < 3) || (pick == 9);
            cc = (pick >= 3 && pick < 6) || (pick == 9);
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 59) == 0) begin
                    cycle(1'b1, 1'b0, 5'd0, hh, cc, "rand_rst");
                end else if (i == 0 && $urandom_range(0, 5) == 0) begin
                    cycle(1'b0, 1'b1, 5'($urandom_range(0, 31)), hh, cc, "rand_load");
                end else if ($urandom_range(0, 49) == 0) begin
                    cycle(1'b0, 1'b0, 5'd0, ~hh, cc, "rand_glitch");
                end else begin
                    cycle(1'b0, 1'b0, 5'd0, hh, cc, "rand");
                end
            end
            $display("scenario random_burst %0d: mode=%0b%0b len=%0d temp=%0d", s, hh, cc, len, temp);
        end

        // Closed loop with a simple hysteresis thermostat, starting from 25
        cycle(1'b0, 1'b1, 5'd25, 1'b0, 1'b0, "loop_load");
        for (int i = 0; i < 200; i++) begin
            hh = (m_temp < 20);
            cc = (m_temp > 23);
            cycle(1'b0, 1'b0, 5'd0, hh, cc, "loop");
        end
        check_val("loop_band", 32'((temp >= 5'd19) && (temp <= 5'd24)), 32'd1);
        $display("scenario closed_loop: temp=%0d fault=%0d", temp, fault);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
